// File: rtl/ft245_pkg.sv
// Shared encodings for the FT245 out-FIFO packet arbiter.
package ft245_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OWN0 = 2'b01,
    ST_OWN1 = 2'b10
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_0    = 2'b01;
  localparam logic [1:0] GNT_1    = 2'b10;

  localparam int DEF_MAX_PKT_LEN = 512;

  function automatic logic [1:0] gnt_of(input logic idx);
    return idx ? GNT_1 : GNT_0;
  endfunction

endpackage

// File: rtl/ft245_rr_pick.sv
// Two-way requester picker: strict priority for requester 1, or round-robin
// where a tie goes to whichever requester did not own the last packet.
module ft245_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_owner,
  input  logic prio,
  output logic winner,
  output logic any_valid
);

  always_comb begin
    any_valid = valid0 | valid1;
    if (prio)
      winner = valid1;
    else if (valid0 && valid1)
      winner = ~last_owner;
    else
      winner = valid1;
  end

endmodule

// File: rtl/ft245_out_arbiter.sv
// Packet-granular arbiter sharing the FT245 bridge out-FIFO write port between
// the command-response stream (req0) and the interrupt/status stream (req1).
//
// state   | meaning
// IDLE    | no owner; arbitrate between valid requesters
// OWN0    | requester 0 owns the write port until last or truncation
// OWN1    | requester 1 owns the write port until last or truncation
module ft245_out_arbiter
  import ft245_pkg::*;
#(
  parameter int MAX_PKT_LEN = DEF_MAX_PKT_LEN,
  parameter int CNT_WIDTH   = 10,
  parameter int PRIO_REQ1   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       out_fifo_wr,
  output logic [7:0] out_fifo_data,
  input  logic       out_fifo_full,
  output logic [1:0] grant,
  output logic       pkt_trunc,
  output logic       trunc_src
);

  state_t               state;
  logic [CNT_WIDTH-1:0] byte_cnt;
  logic                 last_owner;
  logic                 own0, own1, own_idx;
  logic                 cur_valid, cur_last;
  logic                 xfer, cnt_at_max;
  logic                 pick_winner, pick_any;

  ft245_rr_pick u_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_owner (last_owner),
    .prio       (PRIO_REQ1 != 0),
    .winner     (pick_winner),
    .any_valid  (pick_any)
  );

  // Gating with rst_n keeps the write port quiet during the reset cycle itself,
  // so a packet interrupted by reset never leaks another byte.
  assign own0    = rst_n && (state == ST_OWN0);
  assign own1    = rst_n && (state == ST_OWN1);
  assign own_idx = (state == ST_OWN1);

  always_comb begin
    cur_valid     = 1'b0;
    cur_last      = 1'b0;
    out_fifo_data = 8'h00;
    if (own0) begin
      cur_valid     = req0_valid;
      cur_last      = req0_last;
      out_fifo_data = req0_data;
    end else if (own1) begin
      cur_valid     = req1_valid;
      cur_last      = req1_last;
      out_fifo_data = req1_data;
    end
  end

  assign req0_ready  = own0 && !out_fifo_full;
  assign req1_ready  = own1 && !out_fifo_full;
  assign out_fifo_wr = cur_valid && !out_fifo_full;
  assign xfer        = out_fifo_wr;
  // This transfer brings the count up to MAX_PKT_LEN.
  assign cnt_at_max  = (byte_cnt == CNT_WIDTH'(MAX_PKT_LEN - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= GNT_NONE;
      byte_cnt   <= '0;
      last_owner <= 1'b1;
      pkt_trunc  <= 1'b0;
      trunc_src  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          byte_cnt <= '0;
          if (pick_any) begin
            state <= pick_winner ? ST_OWN1 : ST_OWN0;
            grant <= gnt_of(pick_winner);
          end
        end
        ST_OWN0, ST_OWN1: begin
          if (xfer) begin
            if (cur_last) begin
              state      <= ST_IDLE;
              grant      <= GNT_NONE;
              byte_cnt   <= '0;
              last_owner <= own_idx;
            end else if (cnt_at_max) begin
              state      <= ST_IDLE;
              grant      <= GNT_NONE;
              byte_cnt   <= '0;
              last_owner <= own_idx;
              pkt_trunc  <= 1'b1;
              trunc_src  <= own_idx;
            end else if (byte_cnt != '1) begin
              byte_cnt <= byte_cnt + 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_out_arbiter.sv
// Directed bench for ft245_out_arbiter: round-robin/truncation instance (a)
// and strict-priority instance (b) driven from shared byte-stream sources.
module tb_ft245_out_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic [7:0] req0_data, req1_data;
  logic       out_fifo_full;

  logic       a_req0_ready, a_req1_ready, a_wr, a_trunc, a_src;
  logic [7:0] a_data;
  logic [1:0] a_grant;
  logic       b_req0_ready, b_req1_ready, b_wr, b_trunc, b_src;
  logic [7:0] b_data;
  logic [1:0] b_grant;

  always #5 clk = ~clk;

  ft245_out_arbiter #(.MAX_PKT_LEN(4), .CNT_WIDTH(10), .PRIO_REQ1(0)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(a_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(a_req1_ready),
    .out_fifo_wr(a_wr), .out_fifo_data(a_data), .out_fifo_full(out_fifo_full),
    .grant(a_grant), .pkt_trunc(a_trunc), .trunc_src(a_src)
  );

  ft245_out_arbiter #(.MAX_PKT_LEN(4), .CNT_WIDTH(10), .PRIO_REQ1(1)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_last(req0_last), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_last(req1_last), .req1_ready(b_req1_ready),
    .out_fifo_wr(b_wr), .out_fifo_data(b_data), .out_fifo_full(out_fifo_full),
    .grant(b_grant), .pkt_trunc(b_trunc), .trunc_src(b_src)
  );

  logic       use_b;
  logic       s_ready0, s_ready1, s_wr;
  logic [7:0] s_data;
  logic [1:0] s_grant;
  assign s_ready0 = use_b ? b_req0_ready : a_req0_ready;
  assign s_ready1 = use_b ? b_req1_ready : a_req1_ready;
  assign s_wr     = use_b ? b_wr : a_wr;
  assign s_data   = use_b ? b_data : a_data;
  assign s_grant  = use_b ? b_grant : a_grant;

  logic [7:0] q0d[$], q1d[$], wlog[$];
  bit         q0l[$], q1l[$];
  logic [1:0] glog[$];
  bit         en0, en1;
  int         n_checks = 0;
  int         n_errors = 0;
  int         stall_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] wat(input int k);
    return (k < wlog.size()) ? {1'b0, wlog[k]} : 9'h1FF;
  endfunction

  task automatic drive();
    req0_valid = en0 && (q0d.size() > 0);
    req0_data  = (q0d.size() > 0) ? q0d[0] : 8'h00;
    req0_last  = (q0l.size() > 0) ? q0l[0] : 1'b0;
    req1_valid = en1 && (q1d.size() > 0);
    req1_data  = (q1d.size() > 0) ? q1d[0] : 8'h00;
    req1_last  = (q1l.size() > 0) ? q1l[0] : 1'b0;
  endtask

  // Sample mid-cycle, then pop whatever was accepted at the rising edge.
  task automatic tick();
    bit h0, h1;
    @(negedge clk);
    h0 = req0_valid && s_ready0;
    h1 = req1_valid && s_ready1;
    if (s_wr) wlog.push_back(s_data);
    glog.push_back(s_grant);
    if (out_fifo_full && (s_wr || s_ready0 || s_ready1)) stall_bad++;
    @(posedge clk);
    #1;
    if (h0) begin void'(q0d.pop_front()); void'(q0l.pop_front()); end
    if (h1) begin void'(q1d.pop_front()); void'(q1l.pop_front()); end
    drive();
  endtask

  task automatic run_until(input int n);
    int k = 0;
    while (wlog.size() < n && k < 50) begin
      tick();
      k++;
    end
    if (wlog.size() < n) check_val("timeout_writes", wlog.size(), n);
  endtask

  task automatic clear_src();
    q0d.delete(); q0l.delete(); q1d.delete(); q1l.delete();
    en0 = 1'b1; en1 = 1'b1;
    drive();
  endtask

  task automatic do_reset();
    clear_src();
    out_fifo_full = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    wlog.delete();
    glog.delete();
    stall_bad = 0;
  endtask

  task automatic push0(input logic [7:0] d, input bit l);
    q0d.push_back(d); q0l.push_back(l);
  endtask

  task automatic push1(input logic [7:0] d, input bit l);
    q1d.push_back(d); q1l.push_back(l);
  endtask

  initial begin
    use_b = 1'b0;
    out_fifo_full = 1'b0;
    rst_n = 1'b0;
    clear_src();
    @(posedge clk); #1;
    do_reset();
    check_val("rst_grant_a", a_grant, 2'b00);
    check_val("rst_trunc_a", a_trunc, 1'b0);
    check_val("rst_src_a", a_src, 1'b0);
    check_val("rst_wr_a", a_wr, 1'b0);
    check_val("rst_grant_b", b_grant, 2'b00);

    // Reset mid-packet
    for (int i = 0; i < 4; i++) push0(8'h10 + 8'(i), i == 3);
    drive();
    run_until(2);
    rst_n = 1'b0;
    tick();
    check_val("midrst_grant", a_grant, 2'b00);
    check_val("midrst_wr", a_wr, 1'b0);
    check_val("midrst_data", a_data, 8'h00);
    check_val("midrst_ready0", a_req0_ready, 1'b0);
    check_val("midrst_ready1", a_req1_ready, 1'b0);
    clear_src();
    rst_n = 1'b1;
    repeat (4) tick();
    check_val("midrst_count", wlog.size(), 2);
    check_val("midrst_b0", wat(0), 9'h010);
    check_val("midrst_b1", wat(1), 9'h011);

    // Round-robin contention
    do_reset();
    push0(8'hA0, 1'b0); push0(8'hA1, 1'b1); push1(8'hB0, 1'b1);
    drive();
    repeat (7) tick();
    check_val("rr_b0", wat(0), 9'h0A0);
    check_val("rr_b1", wat(1), 9'h0A1);
    check_val("rr_b2", wat(2), 9'h0B0);
    check_val("rr_g1", glog[1], 2'b01);
    check_val("rr_g2", glog[2], 2'b01);
    check_val("rr_gap", glog[3], 2'b00);
    check_val("rr_g4", glog[4], 2'b10);
    check_val("rr_g5", glog[5], 2'b00);

    // Backpressure mid-packet
    do_reset();
    for (int i = 0; i < 4; i++) push1(8'hC0 + 8'(i), i == 3);
    drive();
    run_until(2);
    out_fifo_full = 1'b1;
    repeat (5) tick();
    check_val("bp_hold_grant", a_grant, 2'b10);
    check_val("bp_stall_count", wlog.size(), 2);
    out_fifo_full = 1'b0;
    run_until(4);
    repeat (3) tick();
    check_val("bp_stall_viol", stall_bad, 0);
    check_val("bp_count", wlog.size(), 4);
    for (int i = 0; i < 4; i++) check_val("bp_byte", wat(i), 9'h0C0 + 9'(i));
    check_val("bp_no_trunc", a_trunc, 1'b0);

    // Truncation at MAX_PKT_LEN=4, first from req0 then from req1
    do_reset();
    for (int i = 0; i < 6; i++) push0(8'(i), i == 5);
    drive();
    repeat (10) tick();
    check_val("tr_count", wlog.size(), 6);
    for (int i = 0; i < 6; i++) check_val("tr_byte", wat(i), 9'(i));
    check_val("tr_g4", glog[4], 2'b01);
    check_val("tr_gap", glog[5], 2'b00);
    check_val("tr_regrant", glog[6], 2'b01);
    check_val("tr_flag", a_trunc, 1'b1);
    check_val("tr_src0", a_src, 1'b0);
    for (int i = 0; i < 5; i++) push1(8'h20 + 8'(i), i == 4);
    drive();
    repeat (10) tick();
    check_val("tr_flag_sticky", a_trunc, 1'b1);
    check_val("tr_src1", a_src, 1'b1);

    // Strict priority for requester 1
    use_b = 1'b1;
    do_reset();
    for (int i = 0; i < 8; i++) push0(8'h50 + 8'(i), 1'b1);
    push1(8'h60, 1'b1); push1(8'h61, 1'b1);
    en1 = 1'b0;
    drive();
    tick();
    en1 = 1'b1;
    drive();
    repeat (7) tick();
    check_val("pr_b0", wat(0), 9'h050);
    check_val("pr_b1", wat(1), 9'h060);
    check_val("pr_b2", wat(2), 9'h061);
    check_val("pr_b3", wat(3), 9'h051);
    use_b = 1'b0;

    // Valid gap mid-packet
    do_reset();
    for (int i = 0; i < 4; i++) push1(8'hD0 + 8'(i), i == 3);
    push0(8'hE0, 1'b1);
    en0 = 1'b0;
    drive();
    tick();
    en0 = 1'b1;
    drive();
    run_until(2);
    en1 = 1'b0;
    drive();
    repeat (3) tick();
    for (int i = 0; i < 3; i++) check_val("gap_grant", glog[glog.size() - 1 - i], 2'b10);
    check_val("gap_nowr", wlog.size(), 2);
    en1 = 1'b1;
    drive();
    run_until(5);
    check_val("gap_b2", wat(2), 9'h0D2);
    check_val("gap_b3", wat(3), 9'h0D3);
    check_val("gap_b4", wat(4), 9'h0E0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
